// File: rtl/noc_vc_input_buffer.sv
// Per-VC input FIFOs on a NoC link, drained through a wormhole-locked round-robin arbiter.
// Define NOC_VCBUF_ERR_EN to add the sticky packet-framing error output err.
module noc_vc_input_buffer #(
  parameter int VC_NUM     = 4,
  parameter int FLIT_WIDTH = 64,
  parameter int VC_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [FLIT_WIDTH-1:0]     in_flit,
  output logic [VC_NUM-1:0]         in_vc_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [FLIT_WIDTH-1:0]     out_flit,
  output logic [$clog2(VC_NUM)-1:0] out_vc,
  input  logic [VC_NUM-1:0]         out_vc_ready
`ifdef NOC_VCBUF_ERR_EN
  ,
  output logic                      err
`endif
);
  localparam int VC_W = $clog2(VC_NUM);
  localparam int AW   = $clog2(VC_DEPTH);

  logic [VC_W-1:0]       v_in;
  logic                  wr_en;
  logic                  xfer;
  logic [VC_NUM-1:0]     full;
  logic [VC_NUM-1:0]     empty;
  logic [VC_NUM-1:0]     eligible;
  logic [VC_NUM-1:0]     wr_sel;
  logic [VC_NUM-1:0]     rd_sel;
  logic [AW-1:0]         wr_addr [VC_NUM];
  logic [AW-1:0]         rd_addr [VC_NUM];
  logic [FLIT_WIDTH-1:0] mem [VC_NUM*VC_DEPTH];

  logic                  locked_reg;
  logic [VC_W-1:0]       lock_vc_reg;
  logic [VC_W-1:0]       rr_ptr_reg;
  logic                  stall_reg;
  logic [VC_W-1:0]       stall_vc_reg;
  logic [VC_W-1:0]       grant;
  logic [VC_W-1:0]       scan_vc;
  logic [1:0]            out_type;

  assign v_in        = in_flit[FLIT_WIDTH-3 -: VC_W];
  assign in_ready    = !full[v_in];
  assign in_vc_ready = ~full;
  assign wr_en       = in_valid && in_ready;
  assign xfer        = out_valid && out_ready;
  assign wr_sel      = wr_en ? (VC_NUM'(1) << v_in) : '0;
  assign rd_sel      = xfer ? (VC_NUM'(1) << grant) : '0;
  assign eligible    = ~empty & out_vc_ready;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  for (genvar gi = 0; gi < VC_NUM; gi++) begin : gen_vc
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (wr_sel[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (rd_sel[gi]) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end

    assign empty[gi]   = (wr_ptr_reg == rd_ptr_reg);
    assign full[gi]    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                         (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign wr_addr[gi] = wr_ptr_reg[AW-1:0];
    assign rd_addr[gi] = rd_ptr_reg[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[{v_in, wr_addr[v_in]}] <= in_flit;
  end

  assign out_flit = mem[{grant, rd_addr[grant]}];
  assign out_vc   = grant;
  assign out_type = out_flit[FLIT_WIDTH-1 -: 2];

  // A stalled idle grant is held so a late arrival cannot steal an offered flit.
  always_comb begin
    grant     = rr_ptr_reg;
    out_valid = 1'b0;
    scan_vc   = rr_ptr_reg;
    if (locked_reg) begin
      grant     = lock_vc_reg;
      out_valid = eligible[lock_vc_reg];
    end else if (stall_reg && eligible[stall_vc_reg]) begin
      grant     = stall_vc_reg;
      out_valid = 1'b1;
    end else begin
      for (int i = VC_NUM - 1; i >= 0; i--) begin
        scan_vc = rr_ptr_reg + VC_W'(i);
        if (eligible[scan_vc]) begin
          grant     = scan_vc;
          out_valid = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked_reg   <= 1'b0;
      lock_vc_reg  <= '0;
      rr_ptr_reg   <= '0;
      stall_reg    <= 1'b0;
      stall_vc_reg <= '0;
    end else begin
      stall_reg    <= out_valid && !out_ready;
      stall_vc_reg <= grant;
      if (xfer) begin
        case (out_type)
          2'b01: begin
            locked_reg  <= 1'b1;
            lock_vc_reg <= grant;
          end
          2'b10, 2'b11: begin
            locked_reg <= 1'b0;
            rr_ptr_reg <= grant + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef NOC_VCBUF_ERR_EN
  logic [VC_NUM-1:0] open_reg;
  logic              err_reg;
  logic [1:0]        in_type;

  assign in_type = in_flit[FLIT_WIDTH-1 -: 2];

  // Type bit 0 marks a packet start; a start must find the VC closed, anything else open.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      open_reg <= '0;
      err_reg  <= 1'b0;
    end else if (wr_en) begin
      if (in_type[0] == open_reg[v_in]) err_reg <= 1'b1;
      case (in_type)
        2'b01:        open_reg[v_in] <= 1'b1;
        2'b10, 2'b11: open_reg[v_in] <= 1'b0;
        default: ;
      endcase
    end
  end

  assign err = err_reg;
`endif

endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// Testbench for noc_vc_input_buffer: directed scenarios plus randomized traffic against a queue model.
// Build with NOC_VCBUF_ERR_EN defined to also exercise the sticky err output.
module tb_noc_vc_input_buffer;
  localparam int VC_NUM = 4;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_flit = '0;
  logic [3:0]  in_vc_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_flit;
  logic [1:0]  out_vc;
  logic [3:0]  out_vc_ready = 4'hF;
`ifdef NOC_VCBUF_ERR_EN
  logic        err;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  noc_vc_input_buffer #(.VC_NUM(4), .FLIT_WIDTH(64), .VC_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_flit      (in_flit),
    .in_vc_ready  (in_vc_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_flit     (out_flit),
    .out_vc       (out_vc),
    .out_vc_ready (out_vc_ready)
`ifdef NOC_VCBUF_ERR_EN
    ,
    .err          (err)
`endif
  );

  // Reference model: one queue per VC plus packet-level arbitration state.
  logic [63:0] q [4][$];
  bit          m_locked;
  int          m_lock_vc;
  int          m_rr;
  bit          m_stall;
  int          m_stall_vc;
  bit [3:0]    m_open;
  bit          m_err;

  bit          exp_in_ready;
  bit          exp_out_valid;
  int          exp_vc;
  logic [63:0] exp_flit;
  logic [3:0]  exp_vc_ready;

  function automatic logic [63:0] mk(input logic [1:0] t, input int vc, input logic [31:0] pay);
    return {t, 2'(vc), 28'h0, pay};
  endfunction

  function automatic void model_reset();
    for (int v = 0; v < VC_NUM; v++) q[v].delete();
    m_locked = 0; m_lock_vc = 0; m_rr = 0; m_stall = 0; m_stall_vc = 0;
    m_open = '0; m_err = 0;
  endfunction

  function automatic void model_eval();
    bit el [4];
    int vin;
    int v;
    vin = int'(in_flit[61:60]);
    for (int k = 0; k < VC_NUM; k++) begin
      exp_vc_ready[k] = (q[k].size() < DEPTH);
      el[k] = (q[k].size() > 0) && out_vc_ready[k];
    end
    exp_in_ready  = exp_vc_ready[vin];
    exp_out_valid = 0;
    exp_vc        = 0;
    if (m_locked) begin
      exp_vc = m_lock_vc;
      exp_out_valid = el[m_lock_vc];
    end else if (m_stall && el[m_stall_vc]) begin
      exp_vc = m_stall_vc;
      exp_out_valid = 1;
    end else begin
      for (int k = 0; k < VC_NUM; k++) begin
        v = (m_rr + k) % VC_NUM;
        if (el[v] && !exp_out_valid) begin
          exp_vc = v;
          exp_out_valid = 1;
        end
      end
    end
    exp_flit = exp_out_valid ? q[exp_vc][0] : 64'h0;
  endfunction

  // Advance one clock (negedge to negedge) and apply the transfer rules to the model.
  task automatic tick();
    logic [63:0] f;
    int vin;
    bit wr;
    bit rd;
    model_eval();
    wr  = in_valid && exp_in_ready;
    rd  = exp_out_valid && out_ready;
    vin = int'(in_flit[61:60]);
    @(posedge clk);
    if (rd) begin
      f = q[exp_vc].pop_front();
      case (f[63:62])
        2'b01: begin m_locked = 1; m_lock_vc = exp_vc; end
        2'b10, 2'b11: begin m_locked = 0; m_rr = (exp_vc + 1) % VC_NUM; end
        default: ;
      endcase
    end
    m_stall    = exp_out_valid && !out_ready;
    m_stall_vc = exp_vc;
    if (wr) begin
      if (in_flit[62] == m_open[vin]) m_err = 1;
      if (in_flit[63:62] == 2'b01) m_open[vin] = 1;
      else if (in_flit[63]) m_open[vin] = 0;
      q[vin].push_back(in_flit);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    out_ready = 0; out_vc_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_flit = mk(2'b11, 1, 32'(i)); tick();
    end
    #1;
    checks++;
    if (in_vc_ready !== 4'b1101) begin errors++; $display("FAIL pre_reset_vc_ready got=%b exp=1101", in_vc_ready); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL pre_reset_in_ready got=%b exp=0", in_ready); end
    #2 rst = 1;
    #1;
    checks++;
    if (in_vc_ready !== 4'hF) begin errors++; $display("FAIL reset_vc_ready got=%b exp=1111", in_vc_ready); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
`ifdef NOC_VCBUF_ERR_EN
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
`endif
    in_valid = 0;
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_single();
    logic [63:0] f;
    f = mk(2'b11, 2, 32'h1);
    out_ready = 1; out_vc_ready = 4'hF;
    in_valid = 1; in_flit = f;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_no_passthru got=%b exp=0", out_valid); end
    tick();
    in_valid = 0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_vc !== 2'd2) begin errors++; $display("FAIL single_out got valid=%b vc=%0d exp valid=1 vc=2", out_valid, out_vc); end
    checks++;
    if (out_flit !== f) begin errors++; $display("FAIL single_flit got=%h exp=%h", out_flit, f); end
    tick();
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_vc_ready !== 4'hF) begin errors++; $display("FAIL single_drained got valid=%b vcr=%b exp valid=0 vcr=1111", out_valid, in_vc_ready); end
  endtask

  task automatic test_full();
    logic [63:0] exp_list [3];
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_flit = mk(2'b11, 1, 32'(100 + i)); tick();
    end
    in_flit = mk(2'b11, 1, 32'd104);
    #1;
    checks++;
    if (in_vc_ready !== 4'b1101 || in_ready !== 1'b0) begin errors++; $display("FAIL full_refuse got vcr=%b rdy=%b exp vcr=1101 rdy=0", in_vc_ready, in_ready); end
    out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL full_no_bypass got=%b exp=0", in_ready); end
    checks++;
    if (out_valid !== 1'b1 || out_vc !== 2'd1 || out_flit !== mk(2'b11, 1, 32'd100)) begin errors++; $display("FAIL full_first_out got vc=%0d flit=%h", out_vc, out_flit); end
    tick();
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL full_recover got=%b exp=1", in_ready); end
    tick();
    in_valid = 0;
    exp_list[0] = mk(2'b11, 1, 32'd102);
    exp_list[1] = mk(2'b11, 1, 32'd103);
    exp_list[2] = mk(2'b11, 1, 32'd104);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_flit !== exp_list[i]) begin errors++; $display("FAIL full_drain%0d got valid=%b flit=%h exp=%h", i, out_valid, out_flit, exp_list[i]); end
      tick();
    end
  endtask

  task automatic test_wormhole();
    logic [63:0] b, t;
    b = mk(2'b00, 0, 32'hB0);
    t = mk(2'b10, 0, 32'hE0);
    out_ready = 0;
    in_valid = 1; in_flit = mk(2'b01, 0, 32'hA0); tick();
    out_ready = 1; in_flit = mk(2'b11, 3, 32'h33);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_vc !== 2'd0) begin errors++; $display("FAIL worm_head got valid=%b vc=%0d exp 1/0", out_valid, out_vc); end
    tick();
    in_flit = b;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL worm_locked_idle got valid=%b vc=%0d exp valid=0", out_valid, out_vc); end
    tick();
    in_flit = t;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_vc !== 2'd0 || out_flit !== b) begin errors++; $display("FAIL worm_body got vc=%0d flit=%h exp vc=0 flit=%h", out_vc, out_flit, b); end
    tick();
    in_valid = 0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_vc !== 2'd0 || out_flit !== t) begin errors++; $display("FAIL worm_tail got vc=%0d flit=%h exp vc=0 flit=%h", out_vc, out_flit, t); end
    tick();
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_vc !== 2'd3) begin errors++; $display("FAIL worm_vc3 got valid=%b vc=%0d exp 1/3", out_valid, out_vc); end
    tick();
  endtask

  task automatic test_round_robin();
    out_ready = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_flit = mk(2'b11, i % 2, 32'(200 + i)); tick();
    end
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_vc !== 2'(i % 2)) begin errors++; $display("FAIL rr_grant%0d got valid=%b vc=%0d exp vc=%0d", i, out_valid, out_vc, i % 2); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    in_valid = 1;
    in_flit = mk(2'b01, 0, 32'h10); tick();
    in_flit = mk(2'b11, 1, 32'h11); tick();
    in_flit = mk(2'b00, 0, 32'h12); tick();
    in_flit = mk(2'b10, 0, 32'h13); tick();
    in_valid = 0; out_ready = 1;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_vc !== 2'd0) begin errors++; $display("FAIL bp_head got valid=%b vc=%0d exp 1/0", out_valid, out_vc); end
    tick();
    out_vc_ready = 4'b1110;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_blocked%0d got valid=%b vc=%0d exp valid=0", i, out_valid, out_vc); end
      tick();
    end
    out_vc_ready = 4'hF;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_vc !== 2'd0 || out_flit !== mk(2'b00, 0, 32'h12)) begin errors++; $display("FAIL bp_resume got vc=%0d flit=%h", out_vc, out_flit); end
    tick();
    tick();
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_vc !== 2'd1) begin errors++; $display("FAIL bp_vc1_after got valid=%b vc=%0d exp 1/1", out_valid, out_vc); end
    tick();
  endtask

`ifdef NOC_VCBUF_ERR_EN
  task automatic test_err();
    #1;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_clean got=%b exp=0", err); end
    in_valid = 1; in_flit = mk(2'b00, 2, 32'hBAD);
    tick();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL err_sticky%0d got=%b exp=1", i, err); end
      tick();
    end
    #1 rst = 1;
    #1;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_reset got=%b exp=0", err); end
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      in_flit      = mk(2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom);
      out_ready    = ($urandom_range(0, 3) != 0);
      out_vc_ready = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
      #1;
      model_eval();
      checks++;
      if (in_ready !== exp_in_ready || in_vc_ready !== exp_vc_ready) begin
        errors++; $display("FAIL rand_in cyc=%0d got rdy=%b vcr=%b exp rdy=%b vcr=%b", n, in_ready, in_vc_ready, exp_in_ready, exp_vc_ready);
      end
      checks++;
      if (out_valid !== exp_out_valid) begin errors++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", n, out_valid, exp_out_valid); end
      if (exp_out_valid) begin
        checks++;
        if (out_vc !== 2'(exp_vc) || out_flit !== exp_flit) begin
          errors++; $display("FAIL rand_out cyc=%0d got vc=%0d flit=%h exp vc=%0d flit=%h", n, out_vc, out_flit, exp_vc, exp_flit);
        end
      end
`ifdef NOC_VCBUF_ERR_EN
      checks++;
      if (err !== m_err) begin errors++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", n, err, m_err); end
`endif
      tick();
    end
    in_valid = 0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    test_reset();
    test_single();
    test_full();
    test_wormhole();
    test_round_robin();
    test_backpressure();
`ifdef NOC_VCBUF_ERR_EN
    test_err();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
